// File: rtl/prog_channel_host.sv
// Host-side end of the program core's in/out channels: serves input words on
// request, checks output words against a loaded expected sequence, and reports
// finished/success once the core signals completion.
// Optional feature macro: CHANNEL_HOST_STRICT_EN (output words beyond NOUT are
// errors). When undefined, the compare index wraps modulo NOUT.
module prog_channel_host #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned NIN   = 3,
  parameter int unsigned NOUT  = 6,
  parameter int unsigned AW    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_en,
  input  logic             load_sel,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic             in_req,
  output logic             in_valid,
  output logic [WIDTH-1:0] in_data,
  output logic             in_empty,
  output logic [WIDTH-1:0] in_size,
  input  logic             out_valid,
  input  logic [WIDTH-1:0] out_data,
  output logic             out_ready,
  input  logic             prog_done,
  output logic             finished,
  output logic             success,
  output logic [AW-1:0]    first_bad
);

  localparam int unsigned InW  = (NIN > 1) ? $clog2(NIN) : 1;
  localparam int unsigned OutW = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam logic [AW:0] NinA  = NIN[AW:0];
  localparam logic [AW:0] NoutA = NOUT[AW:0];
  localparam logic [WIDTH-1:0] NinW = NIN[WIDTH-1:0];
`ifndef CHANNEL_HOST_STRICT_EN
  localparam int unsigned NoutLast = NOUT - 1;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StCheck, StDone} state_e;

  state_e state_q, state_d;
  logic [WIDTH-1:0] in_mem  [NIN];
  logic [WIDTH-1:0] exp_mem [NOUT];

  logic [AW:0]      in_pos_q, in_pos_d;
  logic [AW:0]      out_pos_q, out_pos_d;
  logic             err_q, err_d;
  logic [AW-1:0]    bad_q, bad_d;
  logic             in_valid_q, in_valid_d;
  logic [WIDTH-1:0] in_data_q, in_data_d;
  logic             in_empty_q, in_empty_d;
  logic [WIDTH-1:0] in_size_q, in_size_d;
  logic             out_ready_q, out_ready_d;
  logic             finished_q, finished_d;
  logic             success_q, success_d;
  logic [AW-1:0]    first_bad_q, first_bad_d;
`ifndef CHANNEL_HOST_STRICT_EN
  logic [OutW-1:0]  cmp_idx_q, cmp_idx_d;
`endif
  logic             accept;

  // Reset is synchronous, so handshake/status outputs are masked to read 0
  // during the reset cycle itself, before the registers have cleared.
  assign in_valid  = in_valid_q & ~reset;
  assign in_data   = in_data_q;
  assign in_empty  = in_empty_q;
  assign in_size   = in_size_q;
  assign out_ready = out_ready_q & ~reset;
  assign finished  = finished_q & ~reset;
  assign success   = success_q & ~reset;
  assign first_bad = first_bad_q;
  assign accept    = out_valid & out_ready;

  // Stimulus/expected stores: written only in IDLE, never cleared by reset.
  always_ff @(posedge clock) begin
    if (load_en && state_q == StIdle) begin
      if (!load_sel && ({1'b0, load_addr} < NinA)) begin
        in_mem[load_addr[InW-1:0]] <= load_data;
      end
      if (load_sel && ({1'b0, load_addr} < NoutA)) begin
        exp_mem[load_addr[OutW-1:0]] <= load_data;
      end
    end
  end

  // Sequencer, channel positions, checker state and registered outputs.
  always_comb begin
    state_d     = state_q;
    in_pos_d    = in_pos_q;
    out_pos_d   = out_pos_q;
    err_d       = err_q;
    bad_d       = bad_q;
    in_valid_d  = 1'b0;
    in_data_d   = '0;
    in_empty_d  = 1'b0;
    in_size_d   = in_size_q;
    finished_d  = finished_q;
    success_d   = success_q;
    first_bad_d = first_bad_q;
`ifndef CHANNEL_HOST_STRICT_EN
    cmp_idx_d   = cmp_idx_q;
`endif

    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (prog_done) state_d = StCheck;
      StCheck: state_d = StDone;
      default: state_d = StDone;
    endcase

    // Ready lags RUN entry by a cycle and drops as soon as CHECK is taken.
    out_ready_d = (state_q == StRun) && (state_d == StRun);

    if (state_q == StRun && in_req) begin
      in_valid_d = 1'b1;
      if (in_pos_q < NinA) begin
        in_data_d = in_mem[in_pos_q[InW-1:0]];
        in_pos_d  = in_pos_q + 1'b1;
      end else begin
        in_empty_d = 1'b1;
      end
      in_size_d = NinW - WIDTH'(in_pos_d);
    end

    if (accept) begin
      out_pos_d = out_pos_q + 1'b1;
`ifdef CHANNEL_HOST_STRICT_EN
      if (out_pos_q >= NoutA) begin
        if (!err_q) begin
          err_d = 1'b1;
          bad_d = NoutA[AW-1:0];
        end
      end else if (out_data != exp_mem[out_pos_q[OutW-1:0]] && !err_q) begin
        err_d = 1'b1;
        bad_d = out_pos_q[AW-1:0];
      end
`else
      if (out_data != exp_mem[cmp_idx_q] && !err_q) begin
        err_d = 1'b1;
        bad_d = out_pos_q[AW-1:0];
      end
      cmp_idx_d = (cmp_idx_q == NoutLast[OutW-1:0]) ? '0 : cmp_idx_q + 1'b1;
`endif
    end

    if (state_q == StCheck) begin
      finished_d = 1'b1;
`ifdef CHANNEL_HOST_STRICT_EN
      success_d  = !err_q && (out_pos_q == NoutA);
`else
      success_d  = !err_q && (out_pos_q >= NoutA);
`endif
      if (err_q) begin
        first_bad_d = bad_q;
      end else if (out_pos_q < NoutA) begin
        first_bad_d = out_pos_q[AW-1:0];
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      in_pos_q    <= '0;
      out_pos_q   <= '0;
      err_q       <= 1'b0;
      bad_q       <= '1;
      in_valid_q  <= 1'b0;
      in_data_q   <= '0;
      in_empty_q  <= 1'b0;
      in_size_q   <= NinW;
      out_ready_q <= 1'b0;
      finished_q  <= 1'b0;
      success_q   <= 1'b0;
      first_bad_q <= '1;
`ifndef CHANNEL_HOST_STRICT_EN
      cmp_idx_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      in_pos_q    <= in_pos_d;
      out_pos_q   <= out_pos_d;
      err_q       <= err_d;
      bad_q       <= bad_d;
      in_valid_q  <= in_valid_d;
      in_data_q   <= in_data_d;
      in_empty_q  <= in_empty_d;
      in_size_q   <= in_size_d;
      out_ready_q <= out_ready_d;
      finished_q  <= finished_d;
      success_q   <= success_d;
      first_bad_q <= first_bad_d;
`ifndef CHANNEL_HOST_STRICT_EN
      cmp_idx_q   <= cmp_idx_d;
`endif
    end
  end

endmodule
